multdiv_seq: RTL

- Multicycle signed multiply/divide unit. It sits beside the combinational ALU in the execute stage.
- The ALU issues a start pulse with two operands. This unit iterates one bit per cycle and returns the result with a one-cycle ready pulse. The pipeline stalls on that pulse.
- It is the sequential counterpart to the single-cycle bitwise/arithmetic ALU ops and uses the same operand naming.

---
 rtl/multdiv_seq_pkg.sv | 21 ++
 rtl/multdiv_seq_div_restore_step.sv | 24 ++
 rtl/multdiv_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/multdiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// State encodings, default width, iteration-counter sizing and the most-negative operand value.
package multdiv_seq_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int iter_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int ITER_CNT_W = iter_cnt_w(DEF_WIDTH);

  localparam logic [DEF_WIDTH-1:0] MOST_NEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/multdiv_seq_div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Combinational, zero latency; no flow control.
module multdiv_seq_div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // Remainder is always below the divisor, so the shifted value needs one extra bit.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted  = {rem, bit_in};
    diff     = shifted - {1'b0, divisor};
    q_bit    = (shifted >= {1'b0, divisor});
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/multdiv_seq.sv
// Signed multicycle multiply/divide: one bit per cycle, result registered with a one-cycle ready pulse.
// Latency WIDTH+1 edges from start to ready (divide-by-zero: 1); no backpressure, a new start aborts.
import multdiv_seq_pkg::*;

module multdiv_seq #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = iter_cnt_w(WIDTH);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  // MUL: {partial product, multiplier}. DIV: {remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               neg;
  logic               dz;

  logic               start;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod;
  logic               mul_ovf;
  logic [WIDTH-1:0]   div_rem_next;
  logic               div_q_bit;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo;
  logic               div_ovf;

  always_comb begin
    start    = ctrl_MULT | ctrl_DIV;
    mag_a    = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    mag_b    = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    prod     = neg ? (~acc + 1'b1) : acc;
    mul_ovf  = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
    div_next = {div_rem_next, acc[WIDTH-2:0], div_q_bit};
    quo      = neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    // Only MOST_NEG / -1 yields a positive magnitude with the top bit set.
    div_ovf  = acc[WIDTH-1] & ~neg;
  end

  multdiv_seq_div_restore_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc[2*WIDTH-1:WIDTH]),
    .divisor  (opb),
    .bit_in   (acc[WIDTH-1]),
    .rem_next (div_rem_next),
    .q_bit    (div_q_bit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      acc            <= '0;
      opb            <= '0;
      neg            <= 1'b0;
      dz             <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      // Multiply takes priority when both requests arrive together.
      state          <= ctrl_MULT ? ST_MUL : ST_DIV;
      acc            <= {{WIDTH{1'b0}}, (ctrl_MULT ? mag_b : mag_a)};
      opb            <= ctrl_MULT ? mag_a : mag_b;
      neg            <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz             <= ~ctrl_MULT & ~(|data_operandB);
      cnt            <= (~ctrl_MULT & ~(|data_operandB)) ? '0 : CW'(WIDTH);
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      case (state)
        ST_MUL: begin
          if (cnt == '0) begin
            data_result    <= prod[WIDTH-1:0];
            data_exception <= mul_ovf;
            state          <= ST_DONE;
          end else begin
            acc <= mul_next;
            cnt <= cnt - 1'b1;
          end
        end
        ST_DIV: begin
          if (cnt == '0) begin
            data_result    <= dz ? '0 : quo;
            data_exception <= dz | div_ovf;
            state          <= ST_DONE;
          end else begin
            acc <= div_next;
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign data_resultRDY = (state == ST_DONE);
  assign busy           = (state == ST_MUL) || (state == ST_DIV);

endmodule
